// File: rtl/nn_stream_pkg.sv
// Shared constants and types for the matrix-vector layer input stream.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: DATA_W/VEC_N defaults, signed word type, output-register state enum.
package nn_stream_pkg;

   localparam int DATA_W = 16;
   localparam int VEC_N  = 8;

   typedef logic signed [DATA_W-1:0] word_t;

   // Output register of the stream transmitter: empty or holding a valid word.
   typedef enum logic {
      RD_EMPTY = 1'b0,
      RD_HOLD  = 1'b1
   } rd_state_t;

endpackage

// File: rtl/vec_bank_rf.sv
// Two-bank vector register file: 2 x N words, one write port, one read port.
// Latency: write visible after the clock edge; read is combinational.
// Backpressure: none; the caller guarantees a bank is not read and written at once.
// Ports: clk; wr_en/wr_bank/wr_addr/wr_data (sync write); rd_bank/rd_addr -> rd_data.
module vec_bank_rf
   import nn_stream_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int N     = VEC_N,
   parameter int LOGN  = $clog2(N)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [LOGN-1:0]  wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_bank,
   input  logic [LOGN-1:0]  rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   // Contents are deliberately not reset: a bank is only read after the host
   // has written it and committed it.
   logic [WIDTH-1:0] mem [2][N];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/vec_stream_tx.sv
// Ping-pong vector transmitter: host fills/commits banks, block streams words with last.
// Latency: first word valid 2 cycles after the commit cycle; 1 word/cycle sustained.
// Backpressure: m_ready low holds data_out/m_valid; host is held off via wr_ready.
// Ports: clk, reset (sync, active-high); wr_en/wr_addr/wr_data/wr_commit/wr_ready host side;
//        m_valid/m_ready/data_out/last stream side; vec_sent counts accepted vectors.
module vec_stream_tx
   import nn_stream_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int N     = VEC_N,
   parameter int LOGN  = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [LOGN-1:0]  wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_commit,
   output logic             wr_ready,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             last,
   output logic [15:0]      vec_sent
);

   rd_state_t        state, state_nxt;
   logic [1:0]       full, full_nxt;
   logic             wbank, wbank_nxt;
   logic             rbank, rbank_nxt;
   logic [LOGN-1:0]  ridx, ridx_nxt;
   logic [WIDTH-1:0] data_nxt, rd_data;
   logic             last_nxt;
   logic [15:0]      vec_sent_nxt;
   logic             wr_acc, commit_acc, load, hshake, end_of_vec;

   assign wr_ready   = ~full[wbank];
   assign wr_acc     = wr_en & wr_ready;
   assign commit_acc = wr_commit & wr_ready;
   assign m_valid    = (state == RD_HOLD);
   assign hshake     = m_valid & m_ready;
   // Refill the output register whenever it is free or being drained this
   // cycle; this is what keeps the stream gapless under m_ready=1.
   assign load       = (~m_valid | m_ready) & full[rbank];
   assign end_of_vec = (ridx == LOGN'(N - 1));

   vec_bank_rf #(
      .WIDTH (WIDTH),
      .N     (N),
      .LOGN  (LOGN)
   ) u_rf (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_bank (wbank),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_bank (rbank),
      .rd_addr (ridx),
      .rd_data (rd_data)
   );

   always_comb begin
      state_nxt    = state;
      full_nxt     = full;
      wbank_nxt    = wbank;
      rbank_nxt    = rbank;
      ridx_nxt     = ridx;
      data_nxt     = data_out;
      last_nxt     = last;
      vec_sent_nxt = vec_sent;

      // Commit only targets a free bank and free only targets a full bank, so
      // both updates to full_nxt can never hit the same bit.
      if (commit_acc) begin
         full_nxt[wbank] = 1'b1;
         wbank_nxt       = ~wbank;
      end

      if (load) begin
         state_nxt = RD_HOLD;
         data_nxt  = rd_data;
         last_nxt  = end_of_vec;
         if (end_of_vec) begin
            // The last word now lives in data_out, so the bank can be handed
            // back to the host without waiting for its handshake.
            ridx_nxt        = '0;
            full_nxt[rbank] = 1'b0;
            rbank_nxt       = ~rbank;
         end else begin
            ridx_nxt = ridx + LOGN'(1);
         end
      end else if (hshake) begin
         state_nxt = RD_EMPTY;
         last_nxt  = 1'b0;
      end

      if (hshake && last) begin
         vec_sent_nxt = vec_sent + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RD_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         full     <= '0;
         wbank    <= 1'b0;
         rbank    <= 1'b0;
         ridx     <= '0;
         data_out <= '0;
         last     <= 1'b0;
         vec_sent <= '0;
      end else begin
         full     <= full_nxt;
         wbank    <= wbank_nxt;
         rbank    <= rbank_nxt;
         ridx     <= ridx_nxt;
         data_out <= data_nxt;
         last     <= last_nxt;
         vec_sent <= vec_sent_nxt;
      end
   end

endmodule

// File: tb/tb_vec_stream_tx.sv
// Self-checking bench for vec_stream_tx: directed table, corner sequences, random model.
// Latency: n/a.
// Backpressure: drives m_ready with fixed patterns and random stalls.
module tb_vec_stream_tx;
   import nn_stream_pkg::*;

   localparam int N    = VEC_N;
   localparam int LOGN = $clog2(N);
   localparam int NV   = 6;

   typedef logic [15:0] vec_t [N];
   typedef struct {
      logic [15:0] dat;
      logic        lst;
   } beat_t;
   typedef struct {
      vec_t       vals;
      logic [7:0] pat;
      vec_t       exp_out;
      int         exp_sent;
   } tcase_t;

   logic             clk = 1'b0;
   logic             reset, wr_en, wr_commit, m_ready;
   logic [LOGN-1:0]  wr_addr;
   logic [15:0]      wr_data;
   logic             wr_ready, m_valid, last;
   logic [15:0]      data_out, vec_sent;

   int    n_tests = 0;
   int    n_fail  = 0;
   beat_t got[$];

   always #5 clk = ~clk;

   vec_stream_tx dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_commit (wr_commit),
      .wr_ready  (wr_ready),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .data_out  (data_out),
      .last      (last),
      .vec_sent  (vec_sent)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one edge; record the handshake that happened at that edge.
   task automatic step();
      logic        hp;
      logic [15:0] hd;
      logic        hl;
      hp = m_valid && m_ready;
      hd = data_out;
      hl = last;
      @(posedge clk);
      #1;
      if (hp) got.push_back('{dat: hd, lst: hl});
   endtask

   // Step plus the hold rule: a stalled word must still be there next cycle.
   task automatic step_chk();
      logic        stall;
      logic [15:0] pd;
      stall = m_valid && !m_ready;
      pd    = data_out;
      step();
      if (stall) begin
         chk("hold_valid", {31'd0, m_valid}, 32'd1);
         chk("hold_data", {16'd0, data_out}, {16'd0, pd});
      end
   endtask

   task automatic idle();
      wr_en     = 1'b0;
      wr_commit = 1'b0;
   endtask

   // Writes all N words, committing together with the final write.
   task automatic write_vec(input vec_t v);
      for (int i = 0; i < N; i++) begin
         wr_en     = 1'b1;
         wr_addr   = LOGN'(i);
         wr_data   = v[i];
         wr_commit = (i == N - 1);
         step();
      end
      idle();
   endtask

   function automatic vec_t seq(input int start, input int inc);
      vec_t v;
      for (int i = 0; i < N; i++) v[i] = 16'(start + i * inc);
      return v;
   endfunction

   task automatic chk_got(input string name, input vec_t exp);
      chk({name, "_count"}, got.size(), N);
      for (int i = 0; i < N && i < got.size(); i++) begin
         chk({name, "_data"}, {16'd0, got[i].dat}, {16'd0, exp[i]});
         chk({name, "_last"}, {31'd0, got[i].lst}, {31'd0, (i == N - 1)});
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tcase_t      tbl[4];
      vec_t        va, vb, vs;
      logic [15:0] ab[2*N];
      int          cyc;

      tbl[0].vals = seq(1, 1);
      tbl[0].pat  = 8'b0101_0101;
      tbl[0].exp_out = seq(1, 1);
      tbl[0].exp_sent = 2;
      tbl[1].vals = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h8001, 16'h7FFE, 16'h8000};
      tbl[1].pat  = 8'hFF;
      tbl[1].exp_out = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h8001, 16'h7FFE, 16'h8000};
      tbl[1].exp_sent = 3;
      tbl[2].vals = '{16'h1234, 16'hABCD, 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00};
      tbl[2].pat  = 8'b0011_0011;
      tbl[2].exp_out = '{16'h1234, 16'hABCD, 16'h5555, 16'hAAAA, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00};
      tbl[2].exp_sent = 4;
      tbl[3].vals = seq(100, -7);
      tbl[3].pat  = 8'b1000_0001;
      tbl[3].exp_out = '{16'd100, 16'd93, 16'd86, 16'd79, 16'd72, 16'd65, 16'd58, 16'd51};
      tbl[3].exp_sent = 5;

      // Reset values
      reset = 1'b1; m_ready = 1'b0; wr_addr = '0; wr_data = '0; idle();
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_data_out", {16'd0, data_out}, 32'd0);
      chk("rst_last", {31'd0, last}, 32'd0);
      chk("rst_vec_sent", {16'd0, vec_sent}, 32'd0);

      // Latency and back-to-back streaming of one vector
      got.delete();
      m_ready = 1'b1;
      write_vec(seq(1, 1));
      chk("lat_k1_valid", {31'd0, m_valid}, 32'd0);
      step();
      chk("lat_k2_valid", {31'd0, m_valid}, 32'd1);
      chk("lat_k2_data", {16'd0, data_out}, 32'd1);
      for (int i = 2; i <= N; i++) begin
         step();
         chk("gapless_valid", {31'd0, m_valid}, 32'd1);
         chk("gapless_data", {16'd0, data_out}, i);
         chk("gapless_last", {31'd0, last}, {31'd0, (i == N)});
      end
      step();
      chk("lat_done_valid", {31'd0, m_valid}, 32'd0);
      chk("lat_vec_sent", {16'd0, vec_sent}, 32'd1);
      chk_got("lat", seq(1, 1));

      // Table: vectors streamed under fixed m_ready patterns
      for (int t = 0; t < 4; t++) begin
         got.delete();
         m_ready = 1'b0;
         write_vec(tbl[t].vals);
         cyc = 0;
         while (got.size() < N && cyc < 200) begin
            m_ready = tbl[t].pat[cyc % 8];
            step_chk();
            cyc++;
         end
         m_ready = 1'b1;
         repeat (3) step();
         chk("tbl_done_valid", {31'd0, m_valid}, 32'd0);
         chk_got("tbl", tbl[t].exp_out);
         chk("tbl_vec_sent", {16'd0, vec_sent}, tbl[t].exp_sent);
      end

      // Both banks full: extra writes/commit ignored, 16 gapless words
      got.delete();
      m_ready = 1'b0;
      va = seq(1, 1);
      vb = seq(-1, -1);
      for (int i = 0; i < N; i++) begin
         ab[i] = va[i];
         ab[i + N] = vb[i];
      end
      write_vec(va);
      write_vec(vb);
      chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
      chk("full_head", {16'd0, data_out}, 32'd1);
      wr_en = 1'b1; wr_addr = '0; wr_data = 16'h7FFF; wr_commit = 1'b1;
      step();
      wr_commit = 1'b0; wr_addr = LOGN'(3);
      step();
      idle();
      chk("ign_wr_ready", {31'd0, wr_ready}, 32'd0);
      m_ready = 1'b1;
      for (int k = 1; k < 2 * N; k++) begin
         step();
         chk("pp_valid", {31'd0, m_valid}, 32'd1);
         chk("pp_data", {16'd0, data_out}, {16'd0, ab[k]});
         if (k == N - 2) chk("pp_wr_ready_before", {31'd0, wr_ready}, 32'd0);
         if (k == N - 1) chk("pp_wr_ready_rise", {31'd0, wr_ready}, 32'd1);
      end
      step();
      chk("pp_end_valid", {31'd0, m_valid}, 32'd0);
      repeat (3) step();
      chk("pp_no_third", {31'd0, m_valid}, 32'd0);
      chk("pp_count", got.size(), 2 * N);
      chk("pp_vec_sent", {16'd0, vec_sent}, 32'd7);

      // Reset mid-vector
      got.delete();
      m_ready = 1'b1;
      write_vec(seq(1, 1));
      cyc = 0;
      while (got.size() < 3 && cyc < 20) begin
         step();
         cyc++;
      end
      chk("mid_three_accepted", got.size(), 3);
      reset = 1'b1; m_ready = 1'b0;
      step();
      reset = 1'b0;
      chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
      chk("mid_rst_vec_sent", {16'd0, vec_sent}, 32'd0);
      chk("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
      got.delete();
      m_ready = 1'b1;
      write_vec(seq(9, 1));
      cyc = 0;
      while (got.size() < N && cyc < 40) begin
         step_chk();
         cyc++;
      end
      repeat (2) step();
      chk_got("mid", seq(9, 1));
      chk("mid_vec_sent", {16'd0, vec_sent}, 32'd1);

      // Random traffic against a bank-mirror model
      begin
         logic [15:0]     mirror[2][N];
         logic [15:0]     expq[$];
         logic [N-1:0]    mask;
         logic            mw;
         logic [LOGN-1:0] a;
         logic [15:0]     d;
         int              ncom;
         got.delete();
         mask = '0; mw = 1'b0; ncom = 0; cyc = 0;
         while (!(ncom == NV && got.size() == NV * N) && cyc < 4000) begin
            idle();
            m_ready = ($urandom_range(0, 3) != 0);
            if (wr_ready && ncom < NV && $urandom_range(0, 2) != 0) begin
               a = LOGN'($urandom_range(0, N - 1));
               d = 16'($urandom_range(0, 65535));
               wr_en = 1'b1; wr_addr = a; wr_data = d;
               mirror[mw][a] = d;
               mask[a] = 1'b1;
               if (&mask && $urandom_range(0, 1) == 1) begin
                  wr_commit = 1'b1;
                  for (int i = 0; i < N; i++) expq.push_back(mirror[mw][i]);
                  mw = ~mw; mask = '0; ncom++;
               end
            end
            step_chk();
            cyc++;
         end
         idle();
         chk("rnd_in_budget", {31'd0, (cyc < 4000)}, 32'd1);
         chk("rnd_count", got.size(), expq.size());
         for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            chk("rnd_data", {16'd0, got[i].dat}, {16'd0, expq[i]});
            chk("rnd_last", {31'd0, got[i].lst}, {31'd0, (i % N == N - 1)});
         end
         chk("rnd_vec_sent", {16'd0, vec_sent}, 1 + NV);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
